// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 1:8 TDM demultiplexer.
package tdm_pkg;

    localparam int N_CH   = 8;
    localparam int SLOT_W = 3;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: clear to 0, load to 1, increment with wrap, and a strobe on the 7->0 wrap.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              wrap_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SLOT_W'(1);
        end else if (inc_i) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign wrap_o = inc_i && !clear_i && !load1_i && (slot_q == SLOT_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux_1_8.sv
// 1:8 time-division demultiplexer: steers framed slot words into shadow registers
// and publishes a complete frame to all channel outputs at once.
module tdm_demux_1_8
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_frame_sync,
    input  logic [DATA_W-1:0]      i_data,
    output logic [N_CH*DATA_W-1:0] o_ch_data,
    output logic                   o_frame_done,
    output logic [SLOT_W-1:0]      o_slot,
    output logic                   o_locked,
    output logic                   o_sync_err
);

    state_e state_q, state_d;

    logic [SLOT_W-1:0] slot;
    logic              slot_wrap;
    logic              ctr_clear, ctr_load1, ctr_inc;
    logic              shadow_we;
    logic              sync_err_d;
    logic [SLOT_W-1:0] wr_idx;

    // Slot 7 never lands in a shadow reg; it goes straight into the publish register.
    logic [N_CH-2:0][DATA_W-1:0] shadow_q;
    logic [N_CH*DATA_W-1:0]      ch_data_q;
    logic                        frame_done_q;
    logic                        sync_err_q;

    tdm_slot_ctr u_slot_ctr (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clear_i (ctr_clear),
        .load1_i (ctr_load1),
        .inc_i   (ctr_inc),
        .slot_o  (slot),
        .wrap_o  (slot_wrap)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_valid) begin
            unique case (state_q)
                ST_HUNT: if (i_frame_sync) state_d = ST_RUN;
                ST_RUN:  if (!i_frame_sync && slot == '0) state_d = ST_HUNT;
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        ctr_clear  = 1'b0;
        ctr_load1  = 1'b0;
        ctr_inc    = 1'b0;
        shadow_we  = 1'b0;
        sync_err_d = 1'b0;
        if (i_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (i_frame_sync) begin
                        ctr_load1 = 1'b1;
                        shadow_we = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_frame_sync) begin
                        // Sync mid-frame restarts the frame; the partial one is never published.
                        ctr_load1  = 1'b1;
                        shadow_we  = 1'b1;
                        sync_err_d = (slot != '0);
                    end else if (slot == '0) begin
                        ctr_clear  = 1'b1;
                        sync_err_d = 1'b1;
                    end else begin
                        ctr_inc   = 1'b1;
                        shadow_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_idx = ctr_load1 ? '0 : slot;

    // NOTE: the shadow regs are reset even though they are storage, because a reset must clear any partial frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_q     <= '0;
            ch_data_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH - 1; k++) begin
                if (shadow_we && wr_idx == SLOT_W'(k)) begin
                    shadow_q[k] <= i_data;
                end
            end
            if (slot_wrap) begin
                ch_data_q <= {i_data, shadow_q};
            end
            frame_done_q <= slot_wrap;
            sync_err_q   <= sync_err_d;
        end
    end

    assign o_ch_data    = ch_data_q;
    assign o_frame_done = frame_done_q;
    assign o_slot       = slot;
    assign o_locked     = (state_q == ST_RUN);
    assign o_sync_err   = sync_err_q;

endmodule
